// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// default reset PC / NOP word and an address-alignment helper.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IF_FETCH  = 2'd0,
      IF_SQUASH = 2'd1,
      IF_HOLD   = 2'd2
   } if_state_e;

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_SQUASH = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] IF_NOP_WORD = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds while en=0, otherwise loads a fetched
// instruction (load=1) or collapses to a NOP bubble (load=0).
module if_id_reg
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = IF_NOP_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] inst_in,
   input  logic [31:0] pc_plus4_in,
   output logic [31:0] inst_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   always_comb begin
      inst_d  = inst_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (en) begin
         if (load) begin
            inst_d  = inst_in;
            pc4_d   = pc_plus4_in;
            valid_d = 1'b1;
         end else begin
            inst_d  = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q  <= NOP_WORD;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         inst_q  <= inst_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign inst_o     = inst_q;
   assign pc_plus4_o = pc4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, fetch FSM (FETCH/SQUASH/HOLD), one-entry skid
// buffer for words that arrive during a stall, and pending-redirect register.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC,
   parameter logic [31:0] NOP_WORD = IF_NOP_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        is_branch,
   input  logic [31:0] branch_address,
   input  logic        is_rst_IF_ID,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_plus4_ID,
   output logic [31:0] inst_ID,
   output logic        valid_ID,
   output if_state_e   dbg_state
);

   // Memory handshake: a request is outstanding every cycle imem_req=1; the
   // word is taken in the cycle imem_req=1 and imem_ack=1 (possibly the same
   // cycle the request first appears). imem_addr is held until that cycle.

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redir_q, redir_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;

   logic        ack, redirect, deliver, id_en, id_load;
   logic [31:0] pc_plus4, branch_target, id_inst, id_pc4;

   assign imem_req      = !rst && (state_q != ST_HOLD);
   assign imem_addr     = pc_q;
   assign ack           = imem_req && imem_ack;
   assign redirect      = is_branch && !stall;
   assign branch_target = word_align(branch_address);
   assign pc_plus4      = pc_q + 32'd4;
   assign dbg_state     = if_state_e'(state_q);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      redir_d     = redir_q;
      skid_inst_d = skid_inst_q;
      skid_pc4_d  = skid_pc4_q;
      deliver     = 1'b0;
      id_inst     = imem_rdata;
      id_pc4      = pc_plus4;
      case (state_q)
         ST_FETCH: begin
            if (ack) begin
               if (redirect) begin
                  pc_d = branch_target;
               end else begin
                  pc_d = pc_plus4;
                  if (stall) begin
                     skid_inst_d = imem_rdata;
                     skid_pc4_d  = pc_plus4;
                     state_d     = ST_HOLD;
                  end else begin
                     deliver = 1'b1;
                  end
               end
            end else if (redirect) begin
               redir_d = branch_target;
               state_d = ST_SQUASH;
            end
         end
         ST_SQUASH: begin
            // The newest redirect wins, even when it lands on the ack cycle.
            if (ack) begin
               pc_d    = redirect ? branch_target : redir_q;
               state_d = ST_FETCH;
            end else if (redirect) begin
               redir_d = branch_target;
            end
         end
         ST_HOLD: begin
            if (!stall) begin
               state_d = ST_FETCH;
               if (is_branch) begin
                  pc_d = branch_target;
               end else begin
                  deliver = 1'b1;
                  id_inst = skid_inst_q;
                  id_pc4  = skid_pc4_q;
               end
            end
         end
         default: state_d = ST_FETCH;
      endcase
      id_en   = !stall;
      id_load = deliver && !is_rst_IF_ID;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= word_align(RESET_PC);
         redir_q     <= 32'd0;
         skid_inst_q <= 32'd0;
         skid_pc4_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         redir_q     <= redir_d;
         skid_inst_q <= skid_inst_d;
         skid_pc4_q  <= skid_pc4_d;
      end
   end

   if_id_reg #(
      .NOP_WORD(NOP_WORD)
   ) u_if_id_reg (
      .clk         (clk),
      .rst         (rst),
      .en          (id_en),
      .load        (id_load),
      .inst_in     (id_inst),
      .pc_plus4_in (id_pc4),
      .inst_o      (inst_ID),
      .pc_plus4_o  (pc_plus4_ID),
      .valid_o     (valid_ID)
   );

endmodule
